// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants: opcodes, ALU/result-select codes, immediate formats
// and the ID/EX pipeline record.
package riscv_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_t;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memwrite;
        logic        jump;
        logic        branch;
        logic        alusrc;
        logic        illegal;
        logic [1:0]  resultsrc;
        logic [2:0]  alucontrol;
    } id_ex_t;

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bundle: fetch-side inputs, writeback port and the registered ID/EX outputs.
interface id_stage_if;
    logic [31:0] instd;
    logic [31:0] pcd;
    logic [31:0] pc4d;
    logic        flushe;
    logic        stalld;
    logic        regwritew;
    logic [4:0]  rdw;
    logic [31:0] resultw;

    logic [31:0] rd1e;
    logic [31:0] rd2e;
    logic [31:0] imme;
    logic [31:0] pce;
    logic [31:0] pc4e;
    logic [4:0]  rs1e;
    logic [4:0]  rs2e;
    logic [4:0]  rde;
    logic        regwritee;
    logic        memwritee;
    logic        jumpe;
    logic        branche;
    logic        alusrce;
    logic        illegale;
    logic [1:0]  resultsrce;
    logic [2:0]  alucontrole;

    modport master (
        output instd, pcd, pc4d, flushe, stalld, regwritew, rdw, resultw,
        input  rd1e, rd2e, imme, pce, pc4e, rs1e, rs2e, rde,
        input  regwritee, memwritee, jumpe, branche, alusrce, illegale,
        input  resultsrce, alucontrole
    );

    modport slave (
        input  instd, pcd, pc4d, flushe, stalld, regwritew, rdw, resultw,
        output rd1e, rd2e, imme, pce, pc4e, rs1e, rs2e, rde,
        output regwritee, memwritee, jumpe, branche, alusrce, illegale,
        output resultsrce, alucontrole
    );
endinterface

// File: rtl/regfile.sv
// 32x32 register file, two async read ports and one sync write port; x0 is hardwired zero.
// Define ID_WB_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic        we,
    input  logic [4:0]  a3,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (a3 != 5'd0)) begin
            regs[a3] <= wd;
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) begin
            v = '0;
        end else begin
            v = regs[a];
`ifdef ID_WB_BYPASS_EN
            // write-first: the value being written this cycle wins
            if (we && (a3 == a)) v = wd;
`endif
        end
        return v;
    endfunction

    assign rd1 = read_port(a1);
    assign rd2 = read_port(a2);

endmodule

// File: rtl/id_stage.sv
// RV32 decode stage: field split, control/immediate decode, register read, ID/EX register.
// Optional ID_WB_BYPASS_EN (in regfile) gives write-first reads against the writeback port.
module id_stage
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    id_stage_if.slave  bus
);

    logic [6:0]  opcode;
    logic [4:0]  rd_f;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] rd1_p0;
    logic [31:0] rd2_p0;
    immsrc_t     immsrc;
    id_ex_t      id_ex_p0;
    id_ex_t      id_ex_p1;

    assign opcode   = bus.instd[6:0];
    assign rd_f     = bus.instd[11:7];
    assign funct3   = bus.instd[14:12];
    assign rs1_f    = bus.instd[19:15];
    assign rs2_f    = bus.instd[24:20];
    assign funct7b5 = bus.instd[30];

    function automatic logic signed [31:0] imm_ext(input logic [31:0] ins, input immsrc_t src);
        logic signed [31:0] imm;
        case (src)
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = {{20{ins[31]}}, ins[31:20]};
        endcase
        return imm;
    endfunction

    // sub is only reachable from R-type; I-ALU funct3=000 is always addi
    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_en);
        logic [2:0] op;
        case (f3)
            3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .a1  (rs1_f),
        .a2  (rs2_f),
        .we  (bus.regwritew),
        .a3  (bus.rdw),
        .wd  (bus.resultw),
        .rd1 (rd1_p0),
        .rd2 (rd2_p0)
    );

    // ---- p0: combinational decode ----
    always_comb begin
        id_ex_p0     = '0;
        immsrc       = IMM_I;
        id_ex_p0.rd1 = rd1_p0;
        id_ex_p0.rd2 = rd2_p0;
        id_ex_p0.pc  = bus.pcd;
        id_ex_p0.pc4 = bus.pc4d;
        id_ex_p0.rs1 = rs1_f;
        id_ex_p0.rs2 = rs2_f;
        id_ex_p0.rd  = rd_f;
        case (opcode)
            OP_LW: begin
                id_ex_p0.regwrite  = 1'b1;
                id_ex_p0.alusrc    = 1'b1;
                id_ex_p0.resultsrc = RES_MEM;
                id_ex_p0.alucontrol = ALU_ADD;
            end
            OP_SW: begin
                immsrc              = IMM_S;
                id_ex_p0.memwrite   = 1'b1;
                id_ex_p0.alusrc     = 1'b1;
                id_ex_p0.alucontrol = ALU_ADD;
            end
            OP_R: begin
                id_ex_p0.regwrite   = 1'b1;
                id_ex_p0.alucontrol = alu_dec(funct3, funct7b5);
            end
            OP_IALU: begin
                id_ex_p0.regwrite   = 1'b1;
                id_ex_p0.alusrc     = 1'b1;
                id_ex_p0.alucontrol = alu_dec(funct3, 1'b0);
            end
            OP_BEQ: begin
                immsrc              = IMM_B;
                id_ex_p0.branch     = 1'b1;
                id_ex_p0.alucontrol = ALU_SUB;
            end
            OP_JAL: begin
                immsrc              = IMM_J;
                id_ex_p0.regwrite   = 1'b1;
                id_ex_p0.jump       = 1'b1;
                id_ex_p0.resultsrc  = RES_PC4;
                id_ex_p0.alucontrol = ALU_ADD;
            end
            default: id_ex_p0.illegal = 1'b1;
        endcase
        id_ex_p0.imm = imm_ext(bus.instd, immsrc);
    end

    // ---- p1: ID/EX register (reset > flush bubble > stall hold) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_p1 <= '0;
        end else if (bus.flushe) begin
            id_ex_p1 <= '0;
        end else if (!bus.stalld) begin
            id_ex_p1 <= id_ex_p0;
        end
    end

    assign bus.rd1e        = id_ex_p1.rd1;
    assign bus.rd2e        = id_ex_p1.rd2;
    assign bus.imme        = id_ex_p1.imm;
    assign bus.pce         = id_ex_p1.pc;
    assign bus.pc4e        = id_ex_p1.pc4;
    assign bus.rs1e        = id_ex_p1.rs1;
    assign bus.rs2e        = id_ex_p1.rs2;
    assign bus.rde         = id_ex_p1.rd;
    assign bus.regwritee   = id_ex_p1.regwrite;
    assign bus.memwritee   = id_ex_p1.memwrite;
    assign bus.jumpe       = id_ex_p1.jump;
    assign bus.branche     = id_ex_p1.branch;
    assign bus.alusrce     = id_ex_p1.alusrc;
    assign bus.illegale    = id_ex_p1.illegal;
    assign bus.resultsrce  = id_ex_p1.resultsrc;
    assign bus.alucontrole = id_ex_p1.alucontrol;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, flush/stall/reset sequences,
// and randomized traffic against an arithmetic reference model of the decode rules.
module tb_id_stage;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memwrite;
        logic        jump;
        logic        branch;
        logic        alusrc;
        logic        illegal;
        logic [1:0]  resultsrc;
        logic [2:0]  alucontrol;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        wr;
        logic [4:0]  rdw;
        logic [31:0] wdata;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rde;
        logic [2:0]  alu;
        logic        regw;
        logic        memw;
        logic        br;
        logic        ill;
        logic        chk_imm;
    } vec_t;

    logic clk;
    logic rst;
    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_regs [32];
    exp_t        m_out;
    bit          m_chk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t dut_out();
        exp_t o;
        o.rd1 = bus.rd1e;          o.rd2 = bus.rd2e;        o.imm = bus.imme;
        o.pc = bus.pce;            o.pc4 = bus.pc4e;
        o.rs1 = bus.rs1e;          o.rs2 = bus.rs2e;        o.rd = bus.rde;
        o.regwrite = bus.regwritee; o.memwrite = bus.memwritee;
        o.jump = bus.jumpe;        o.branch = bus.branche;  o.alusrc = bus.alusrce;
        o.illegal = bus.illegale;  o.resultsrc = bus.resultsrce;
        o.alucontrol = bus.alucontrole;
        return o;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (bus.regwritew && bus.rdw == idx) return bus.resultw;
`endif
        return m_regs[idx];
    endfunction

    function automatic logic [2:0] ref_alu(input logic [2:0] f3, input bit is_r, input logic b30);
        if (f3 == 3'd0) return (is_r && b30) ? 3'd1 : 3'd0;
        if (f3 == 3'd2) return 3'd5;
        if (f3 == 3'd6) return 3'd3;
        if (f3 == 3'd7) return 3'd2;
        return 3'd0;
    endfunction

    function automatic bit imm_defined(input logic [6:0] opc);
        return opc == 7'b0000011 || opc == 7'b0100011 || opc == 7'b0010011 ||
               opc == 7'b1100011 || opc == 7'b1101111;
    endfunction

    // Immediates rebuilt as weighted bit sums rather than concatenations
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] pc4);
        exp_t e;
        int   imm_i, imm_s, imm_b, imm_j;
        e = '0;
        imm_i = int'($signed(ins[31:20]));
        imm_s = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
        imm_b = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                + int'(ins[11:8]) * 2;
        imm_j = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                + int'(ins[30:21]) * 2;
        e.rd1 = ref_read(ins[19:15]);
        e.rd2 = ref_read(ins[24:20]);
        e.pc = pc; e.pc4 = pc4;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        case (ins[6:0])
            7'b0000011: begin e.regwrite = 1; e.alusrc = 1; e.resultsrc = 2'b01; e.imm = imm_i; end
            7'b0100011: begin e.memwrite = 1; e.alusrc = 1; e.imm = imm_s; end
            7'b0110011: begin e.regwrite = 1; e.alucontrol = ref_alu(ins[14:12], 1, ins[30]); end
            7'b0010011: begin
                e.regwrite = 1; e.alusrc = 1; e.imm = imm_i;
                e.alucontrol = ref_alu(ins[14:12], 0, ins[30]);
            end
            7'b1100011: begin e.branch = 1; e.alucontrol = 3'd1; e.imm = imm_b; end
            7'b1101111: begin e.regwrite = 1; e.jump = 1; e.resultsrc = 2'b10; e.imm = imm_j; end
            default:    e.illegal = 1;
        endcase
        return e;
    endfunction

    // One clock: predict, take the edge, update the model, settle to edge+1
    task automatic cycle();
        exp_t        nxt;
        bit          nchk;
        bit          w;
        logic [4:0]  widx;
        logic [31:0] wval;
        if (rst)             begin nxt = '0; nchk = 1; end
        else if (bus.flushe) begin nxt = '0; nchk = 1; end
        else if (bus.stalld) begin nxt = m_out; nchk = m_chk; end
        else begin
            nxt  = ref_decode(bus.instd, bus.pcd, bus.pc4d);
            nchk = imm_defined(bus.instd[6:0]);
        end
        w = !rst && bus.regwritew && (bus.rdw != 5'd0);
        widx = bus.rdw;
        wval = bus.resultw;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else if (w) begin
            m_regs[widx] = wval;
        end
        m_out = nxt;
        m_chk = nchk;
        #1;
    endtask

    task automatic set_in(input logic [31:0] ins, input logic fl, input logic st,
                          input logic we, input logic [4:0] rdw, input logic [31:0] wd);
        bus.instd = ins; bus.flushe = fl; bus.stalld = st;
        bus.regwritew = we; bus.rdw = rdw; bus.resultw = wd;
    endtask

    vec_t vecs [11];

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        exp_t        a, e;

        vecs[0]  = '{32'h00000013, 1'b1, 5'd1, 32'd5,       32'd0, 32'd0, 32'd0, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{32'h00000013, 1'b1, 5'd2, 32'd7,       32'd0, 32'd0, 32'd0, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{32'h002081B3, 1'b0, 5'd0, 32'd0,       32'd5, 32'd7, 32'd0, 5'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'hFE208CE3, 1'b0, 5'd0, 32'd0,       32'd5, 32'd7, 32'hFFFFFFF8, 5'd25, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef ID_WB_BYPASS_EN
        vecs[4]  = '{32'h002081B3, 1'b1, 5'd1, 32'hDEADBEEF, 32'hDEADBEEF, 32'd7, 32'd0, 5'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        vecs[4]  = '{32'h002081B3, 1'b1, 5'd1, 32'hDEADBEEF, 32'd5, 32'd7, 32'd0, 5'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        vecs[5]  = '{32'h002081B3, 1'b0, 5'd0, 32'd0,       32'hDEADBEEF, 32'd7, 32'd0, 5'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h002001B3, 1'b1, 5'd0, 32'h1234,    32'd0, 32'd7, 32'd0, 5'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h002001B3, 1'b0, 5'd0, 32'd0,       32'd0, 32'd7, 32'd0, 5'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'hFFFFFFFF, 1'b0, 5'd0, 32'd0,       32'd0, 32'd0, 32'd0, 5'd31, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{32'h0020A223, 1'b0, 5'd0, 32'd0,       32'hDEADBEEF, 32'd7, 32'd4, 5'd4, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'hFFC12203, 1'b0, 5'd0, 32'd0,       32'd7, 32'd0, 32'hFFFFFFFC, 5'd4, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_out = '0;
        m_chk = 1;
        rst = 1'b1;
        bus.pcd = '0; bus.pc4d = '0;
        set_in(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("reset_outputs_zero", {31'd0, dut_out() == '0}, 32'd1);
        cycle();
        cycle();
        rst = 1'b0;

        // ---- directed vector table ----
        for (int i = 0; i < 11; i++) begin
            bus.pcd  = 32'h100 + 32'(i * 4);
            bus.pc4d = bus.pcd + 32'd4;
            set_in(vecs[i].instr, 1'b0, 1'b0, vecs[i].wr, vecs[i].rdw, vecs[i].wdata);
            cycle();
            chk($sformatf("v%0d.rd1e", i), bus.rd1e, vecs[i].rd1);
            chk($sformatf("v%0d.rd2e", i), bus.rd2e, vecs[i].rd2);
            chk($sformatf("v%0d.rde", i), {27'd0, bus.rde}, {27'd0, vecs[i].rde});
            chk($sformatf("v%0d.alucontrole", i), {29'd0, bus.alucontrole}, {29'd0, vecs[i].alu});
            chk($sformatf("v%0d.regwritee", i), {31'd0, bus.regwritee}, {31'd0, vecs[i].regw});
            chk($sformatf("v%0d.memwritee", i), {31'd0, bus.memwritee}, {31'd0, vecs[i].memw});
            chk($sformatf("v%0d.branche", i), {31'd0, bus.branche}, {31'd0, vecs[i].br});
            chk($sformatf("v%0d.illegale", i), {31'd0, bus.illegale}, {31'd0, vecs[i].ill});
            chk($sformatf("v%0d.pce", i), bus.pce, 32'h100 + 32'(i * 4));
            if (vecs[i].chk_imm)
                chk($sformatf("v%0d.imme", i), bus.imme, vecs[i].imm);
        end

        // ---- stall holds outputs while writeback continues ----
        set_in(32'h0020A223, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle();
        set_in(32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 5'd7, 32'h55);
        cycle();
        chk("stall.imme", bus.imme, 32'd4);
        chk("stall.memwritee", {31'd0, bus.memwritee}, 32'd1);
        chk("stall.illegale", {31'd0, bus.illegale}, 32'd0);
        set_in(32'h000381B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle();
        chk("stall_wb.rd1e", bus.rd1e, 32'h55);

        // ---- flush and stall together on a valid lw ----
        set_in(32'hFFC12203, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        cycle();
        chk("flush_stall.regwritee", {31'd0, bus.regwritee}, 32'd0);
        chk("flush_stall.rde", {27'd0, bus.rde}, 32'd0);
        chk("flush_stall.all_zero", {31'd0, dut_out() == '0}, 32'd1);

        // ---- reset mid-stream clears outputs at once and blocks writes ----
        set_in(32'h002081B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle();
        chk("pre_rst.rd1e", bus.rd1e, 32'hDEADBEEF);
        #1;
        rst = 1'b1;
        set_in(32'h002081B3, 1'b1, 1'b1, 1'b1, 5'd5, 32'hAAAA);
        #1;
        chk("rst_async.rd1e", bus.rd1e, 32'd0);
        chk("rst_async.regwritee", {31'd0, bus.regwritee}, 32'd0);
        chk("rst_async.all_zero", {31'd0, dut_out() == '0}, 32'd1);
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_out = '0;
        cycle();
        rst = 1'b0;
        set_in(32'h005081B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle();
        chk("post_rst.x1", bus.rd1e, 32'd0);
        chk("post_rst.x5_no_write", bus.rd2e, 32'd0);

        // ---- randomized traffic against the reference model ----
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            case ($urandom_range(0, 6))
                0:       ins = {r[31:7], 7'b0000011};
                1:       ins = {r[31:7], 7'b0100011};
                2:       ins = {1'b0, r[30], 5'd0, r[24:7], 7'b0110011};
                3:       ins = {r[31:7], 7'b0010011};
                4:       ins = {r[31:7], 7'b1100011};
                5:       ins = {r[31:7], 7'b1101111};
                default: ins = {r[31:7], 7'b1110111};
            endcase
            bus.pcd  = $urandom & 32'hFFFFFFFC;
            bus.pc4d = bus.pcd + 32'd4;
            set_in(ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0),
                   ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 2) == 0) ? ins[19:15] : 5'($urandom_range(0, 31)),
                   $urandom);
            cycle();
            a = dut_out();
            e = m_out;
            if (!m_chk) begin a.imm = '0; e.imm = '0; end
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL rand[%0d]: got %h expected %h", n, a, e);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
